// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two valid/ready requesters.
// One operation in flight: operands are latched on accept, the result is latched one cycle later.
module alu_arbiter #(
    parameter int W    = 4,
    parameter int OC_W = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [OC_W-1:0] req0_oc,
    input  logic [W-1:0]    req0_a,
    input  logic [W-1:0]    req0_b,
    input  logic [OC_W-1:0] req1_oc,
    input  logic [W-1:0]    req1_a,
    input  logic [W-1:0]    req1_b,
    output logic [1:0]      resp_valid,
    input  logic [1:0]      resp_ready,
    output logic [W-1:0]    resp_f,
    output logic [OC_W-1:0] alu_oc,
    output logic [W-1:0]    alu_a,
    output logic [W-1:0]    alu_b,
    input  logic [W-1:0]    alu_f,
    output logic            busy,
    output logic            owner
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic            owner_q, owner_d;
    logic [OC_W-1:0] alu_oc_q, alu_oc_d;
    logic [W-1:0]    alu_a_q, alu_a_d;
    logic [W-1:0]    alu_b_q, alu_b_d;
    logic [W-1:0]    resp_f_q, resp_f_d;
    logic            grant_s;
    logic [1:0]      req_ready_s;
    logic [1:0]      resp_valid_s;

    // Grant: on contention the requester not served last wins; otherwise whoever is valid.
    always_comb begin
        if (req_valid == 2'b11) begin
            grant_s = ~last_grant_q;
        end else if (req_valid[0]) begin
            grant_s = 1'b0;
        end else begin
            grant_s = 1'b1;
        end
    end

    // Next-state, operand/result latching and handshake decode.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        alu_oc_d     = alu_oc_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        resp_f_d     = resp_f_q;
        req_ready_s  = 2'b00;
        resp_valid_s = 2'b00;
        case (state_q)
            IDLE: begin
                if (req_valid != 2'b00) begin
                    req_ready_s = grant_s ? 2'b10 : 2'b01;
                    owner_d     = grant_s;
                    alu_oc_d    = grant_s ? req1_oc : req0_oc;
                    alu_a_d     = grant_s ? req1_a  : req0_a;
                    alu_b_d     = grant_s ? req1_b  : req0_b;
                    state_d     = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                resp_f_d = alu_f;
                state_d  = RESP;
            end
            RESP: begin
                resp_valid_s[owner_q] = 1'b1;
                // Only the owner's resp_ready completes the response.
                if (resp_ready[owner_q]) begin
                    last_grant_d = owner_q;
                    state_d      = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            alu_oc_q     <= {OC_W{1'b0}};
            alu_a_q      <= {W{1'b0}};
            alu_b_q      <= {W{1'b0}};
            resp_f_q     <= {W{1'b0}};
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            alu_oc_q     <= alu_oc_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            resp_f_q     <= resp_f_d;
        end
    end

    assign req_ready  = req_ready_s;
    assign resp_valid = resp_valid_s;
    assign resp_f     = resp_f_q;
    assign alu_oc     = alu_oc_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign busy       = (state_q != IDLE);
    assign owner      = owner_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a local reference ALU wired to the alu_* ports.
module tb_alu_arbiter;

    logic       clk;
    logic       rst_n;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [2:0] req0_oc, req1_oc;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0] resp_valid;
    logic [1:0] resp_ready;
    logic [3:0] resp_f;
    logic [2:0] alu_oc;
    logic [3:0] alu_a, alu_b, alu_f;
    logic       busy;
    logic       owner;

    int n_cmp = 0;
    int n_err = 0;
    int acc0 = 0;
    int rsp0 = 0;
    int rsp1 = 0;

    typedef struct {
        logic       r;
        logic [2:0] oc;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] f;
    } vec_t;

    vec_t tbl[10];

    alu_arbiter #(.W(4), .OC_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_oc(req0_oc), .req0_a(req0_a), .req0_b(req0_b),
        .req1_oc(req1_oc), .req1_a(req1_a), .req1_b(req1_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_f(resp_f),
        .alu_oc(alu_oc), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
        .busy(busy), .owner(owner)
    );

    function automatic logic [3:0] alu_model(input logic [2:0] oc, input logic [3:0] a, input logic [3:0] b);
        case (oc)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ~a;
            3'd6:    return {a[2:0], 1'b0};
            3'd7:    return b;
            default: return 4'd0;
        endcase
    endfunction

    assign alu_f = alu_model(alu_oc, alu_a, alu_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshake monitor, sampled mid-low-phase when everything is settled.
    always @(negedge clk) begin
        #4;
        if (rst_n) begin
            if (req_valid[0] && req_ready[0]) acc0++;
            if (resp_valid[0] && resp_ready[0]) rsp0++;
            if (resp_valid[1] && resp_ready[1]) rsp1++;
        end
    end

    function automatic logic [1:0] onehot(input logic r);
        return r ? 2'b10 : 2'b01;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input logic r, input logic [2:0] oc, input logic [3:0] a, input logic [3:0] b);
        if (r) begin
            req1_oc = oc; req1_a = a; req1_b = b;
        end else begin
            req0_oc = oc; req0_a = a; req0_b = b;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 2'b00;
        resp_ready = 2'b00;
        step();
        step();
        rst_n = 1'b1;
        #1;
    endtask

    // One isolated operation with the response taken in the first RESP cycle.
    task automatic do_op(input logic r, input logic [2:0] oc, input logic [3:0] a, input logic [3:0] b, input logic [3:0] f);
        set_req(r, oc, a, b);
        req_valid  = onehot(r);
        resp_ready = onehot(r);
        #1;
        chk("accept_ready", {30'd0, req_ready}, {30'd0, onehot(r)});
        step();
        req_valid = 2'b00;
        #1;
        chk("exec_busy", {31'd0, busy}, 32'd1);
        chk("exec_owner", {31'd0, owner}, {31'd0, r});
        chk("exec_alu_oc", {29'd0, alu_oc}, {29'd0, oc});
        chk("exec_alu_a", {28'd0, alu_a}, {28'd0, a});
        chk("exec_alu_b", {28'd0, alu_b}, {28'd0, b});
        chk("exec_no_resp", {30'd0, resp_valid}, 32'd0);
        step();
        chk("resp_valid", {30'd0, resp_valid}, {30'd0, onehot(r)});
        chk("resp_f", {28'd0, resp_f}, {28'd0, f});
        step();
        chk("back_idle", {31'd0, busy}, 32'd0);
        chk("idle_no_resp", {30'd0, resp_valid}, 32'd0);
        resp_ready = 2'b00;
    endtask

    initial begin
        logic [3:0] cexp [4];
        logic [10:0] v;

        tbl[0] = '{1'b0, 3'd0, 4'h3, 4'h5, 4'h8};
        tbl[1] = '{1'b1, 3'd1, 4'h3, 4'h5, 4'hE};
        tbl[2] = '{1'b0, 3'd2, 4'hC, 4'hA, 4'h8};
        tbl[3] = '{1'b1, 3'd3, 4'h5, 4'hA, 4'hF};
        tbl[4] = '{1'b0, 3'd4, 4'hF, 4'h6, 4'h9};
        tbl[5] = '{1'b1, 3'd5, 4'h3, 4'h0, 4'hC};
        tbl[6] = '{1'b0, 3'd6, 4'h9, 4'h0, 4'h2};
        tbl[7] = '{1'b1, 3'd7, 4'h0, 4'h7, 4'h7};
        tbl[8] = '{1'b1, 3'd0, 4'hF, 4'h1, 4'h0};
        tbl[9] = '{1'b0, 3'd1, 4'h0, 4'h1, 4'hF};

        rst_n = 1'b0;
        req_valid = 2'b00;
        resp_ready = 2'b00;
        req0_oc = 3'd0; req0_a = 4'd0; req0_b = 4'd0;
        req1_oc = 3'd0; req1_a = 4'd0; req1_b = 4'd0;
        @(negedge clk);
        do_reset();

        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
        chk("rst_resp_valid", {30'd0, resp_valid}, 32'd0);
        chk("rst_alu", {21'd0, alu_oc, alu_a, alu_b}, 32'd0);
        chk("rst_resp_f", {28'd0, resp_f}, 32'd0);
        chk("rst_owner", {31'd0, owner}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            do_op(tbl[i].r, tbl[i].oc, tbl[i].a, tbl[i].b, tbl[i].f);
        end

        // Contention: both valid throughout, grants must alternate 0,1,0,1.
        do_reset();
        cexp[0] = 4'h8; cexp[1] = 4'h5; cexp[2] = 4'hE; cexp[3] = 4'hF;
        set_req(1'b0, 3'd0, 4'h3, 4'h5);
        set_req(1'b1, 3'd1, 4'h9, 4'h4);
        req_valid = 2'b11;
        resp_ready = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("cont_grant", {30'd0, req_ready}, {30'd0, onehot(k[0])});
            step();
            chk("cont_owner", {31'd0, owner}, {31'd0, k[0]});
            chk("cont_exec_ready", {30'd0, req_ready}, 32'd0);
            if (k == 0) set_req(1'b0, 3'd3, 4'hC, 4'hA);
            else if (k == 1) set_req(1'b1, 3'd4, 4'hA, 4'h5);
            else set_req(k[0], 3'd7, 4'h0, 4'h0);
            step();
            chk("cont_resp_ready", {30'd0, req_ready}, 32'd0);
            chk("cont_resp_valid", {30'd0, resp_valid}, {30'd0, onehot(k[0])});
            chk("cont_resp_f", {28'd0, resp_f}, {28'd0, cexp[k]});
            step();
        end
        req_valid = 2'b00;
        resp_ready = 2'b00;
        #1;

        // Backpressure on requester 1; non-owner resp_ready must be ignored.
        set_req(1'b1, 3'd5, 4'h6, 4'h0);
        req_valid = 2'b10;
        #1;
        chk("bp_grant1", {30'd0, req_ready}, 32'd2);
        step();
        req_valid = 2'b11;
        set_req(1'b0, 3'd7, 4'h1, 4'h4);
        step();
        resp_ready = 2'b01;
        for (int i = 0; i < 5; i++) begin
            chk("bp_resp_valid", {30'd0, resp_valid}, 32'd2);
            chk("bp_resp_f", {28'd0, resp_f}, 32'h9);
            chk("bp_no_ready", {30'd0, req_ready}, 32'd0);
            chk("bp_busy", {31'd0, busy}, 32'd1);
            step();
        end
        resp_ready = 2'b10;
        step();
        chk("bp_release_grant0", {30'd0, req_ready}, 32'd1);
        resp_ready = 2'b01;
        step();
        req_valid = 2'b00;
        step();
        chk("bp_req0_resp", {30'd0, resp_valid}, 32'd1);
        chk("bp_req0_f", {28'd0, resp_f}, 32'h4);
        step();
        resp_ready = 2'b00;

        // Reset in EXEC discards the operation and restores requester 0 priority.
        set_req(1'b0, 3'd0, 4'h7, 4'h6);
        req_valid = 2'b01;
        #1;
        chk("mr_accept", {30'd0, req_ready}, 32'd1);
        step();
        chk("mr_exec_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        req_valid = 2'b00;
        step();
        chk("mr_busy", {31'd0, busy}, 32'd0);
        chk("mr_resp_valid", {30'd0, resp_valid}, 32'd0);
        chk("mr_alu", {21'd0, alu_oc, alu_a, alu_b}, 32'd0);
        rst_n = 1'b1;
        set_req(1'b0, 3'd2, 4'hF, 4'h3);
        set_req(1'b1, 3'd3, 4'h0, 4'h1);
        req_valid = 2'b11;
        resp_ready = 2'b01;
        #1;
        chk("mr_first_grant", {30'd0, req_ready}, 32'd1);
        step();
        req_valid = 2'b00;
        step();
        chk("mr_resp_valid2", {30'd0, resp_valid}, 32'd1);
        chk("mr_resp_f", {28'd0, resp_f}, 32'h3);
        step();
        chk("mr_idle", {31'd0, busy}, 32'd0);
        resp_ready = 2'b00;

        // Exhaustive sweep on requester 0.
        acc0 = 0; rsp0 = 0; rsp1 = 0;
        for (int i = 0; i < 2048; i++) begin
            v = i[10:0];
            do_op(1'b0, v[10:8], v[7:4], v[3:0], alu_model(v[10:8], v[7:4], v[3:0]));
        end
        step();
        chk("sweep_accepts", acc0, 32'd2048);
        chk("sweep_responses", rsp0, 32'd2048);
        chk("sweep_no_req1_resp", rsp1, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
